sync_pulse_src: RTL and testbench

- Source-side companion to the destination pulse synchronizer. Runs in the sending clock domain.
- Converts single-cycle event strobes into pulses that are guaranteed to be held high for a minimum time and spaced low for a minimum time, so the destination-side stretcher/synchronizer can capture every one.
- Events that arrive while a pulse is in flight are counted and replayed in order; none are merged (unless the optional feature is compiled in).

---
 rtl/sync_pulse_src.sv | 138 +++++++++++++
 tb/tb_sync_pulse_src.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_pulse_src.sv
// Source-domain pulse shaper: turns event strobes into min-high/min-low pulses with a backlog.
// Optional SYNC_PULSE_SRC_COALESCE_EN collapses the backlog to a single pending flag.
module sync_pulse_src #(
    parameter int C_HIGH_CYCLES = 4,
    parameter int C_LOW_CYCLES  = 4,
    parameter int C_PEND_W      = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                event_i,
    output logic                pulse_o,
    output logic                busy_o,
    output logic [C_PEND_W-1:0] pending_o,
    output logic                overflow_o
);

    localparam int C_MAXC = (C_HIGH_CYCLES > C_LOW_CYCLES) ? C_HIGH_CYCLES : C_LOW_CYCLES;
    localparam int C_TW   = (C_MAXC > 1) ? $clog2(C_MAXC) : 1;

    localparam logic [C_TW-1:0] C_HLAST = C_TW'(C_HIGH_CYCLES - 1);
    localparam logic [C_TW-1:0] C_LLAST = C_TW'(C_LOW_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [C_TW-1:0]     timer_q, timer_d;
    logic [C_PEND_W-1:0] pend_q, pend_d;
    logic                pulse_q, pulse_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;

    logic work;
    logic start;
    logic from_bl;

    assign work    = (pend_q != '0) || event_i;
    assign from_bl = start && (pend_q != '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        start   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (work) begin
                    start   = 1'b1;
                    state_d = S_HIGH;
                    timer_d = '0;
                end
            end
            S_HIGH: begin
                if (timer_q == C_HLAST) begin
                    state_d = S_LOW;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_LOW: begin
                if (timer_q == C_LLAST) begin
                    timer_d = '0;
                    if (work) begin
                        start   = 1'b1;
                        state_d = S_HIGH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

`ifdef SYNC_PULSE_SRC_COALESCE_EN
    // Backlog is one flag; extra events merge into the single queued pulse.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = 1'b0;
        if (from_bl) begin
            pend_d = {{(C_PEND_W-1){1'b0}}, event_i};
        end else if (event_i && !start) begin
            pend_d = {{(C_PEND_W-1){1'b0}}, 1'b1};
        end
    end
`else
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (from_bl) begin
            if (!event_i) begin
                pend_d = pend_q - 1'b1;
            end
        end else if (event_i && !start) begin
            if (pend_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end
    end
`endif

    assign pulse_d = (state_d == S_HIGH);
    assign busy_d  = (state_d != S_IDLE) || (pend_d != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pulse_o    = pulse_q;
    assign busy_o     = busy_q;
    assign pending_o  = pend_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_sync_pulse_src.sv
// Bench for sync_pulse_src: directed scenarios plus random traffic vs. a timing model.
// Honours SYNC_PULSE_SRC_COALESCE_EN the same way the design does.
module tb_sync_pulse_src;

    localparam int H  = 4;
    localparam int L  = 4;
    localparam int W  = 4;
    localparam int HL = H + L;
`ifdef SYNC_PULSE_SRC_COALESCE_EN
    localparam int CAP  = 1;
    localparam bit COAL = 1'b1;
`else
    localparam int CAP  = (1 << W) - 1;
    localparam bit COAL = 1'b0;
`endif

    logic         CLK;
    logic         RST;
    logic         event_i;
    logic         pulse_o;
    logic         busy_o;
    logic [W-1:0] pending_o;
    logic         overflow_o;

    sync_pulse_src #(
        .C_HIGH_CYCLES(H),
        .C_LOW_CYCLES (L),
        .C_PEND_W     (W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .event_i   (event_i),
        .pulse_o   (pulse_o),
        .busy_o    (busy_o),
        .pending_o (pending_o),
        .overflow_o(overflow_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: cycles since the last pulse start, backlog count, sticky overflow.
    int m_since  = HL;
    int m_bl     = 0;
    int m_ovf    = 0;
    int m_starts = 0;

    always @(posedge CLK) begin
        if (RST) begin
            m_since = HL;
            m_bl    = 0;
            m_ovf   = 0;
        end else if ((m_since + 1 >= HL) && (m_bl != 0 || event_i)) begin
            m_since = 0;
            m_starts++;
            if (m_bl != 0) m_bl = m_bl - 1 + int'(event_i);
        end else begin
            if (m_since < HL) m_since++;
            if (event_i) begin
                if (m_bl == CAP) begin
                    if (!COAL) m_ovf = 1;
                end else begin
                    m_bl++;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("pulse_o", int'(pulse_o), int'(m_since < H));
            chk("busy_o", int'(busy_o), int'(m_since < HL || m_bl != 0));
            chk("pending_o", int'(pending_o), m_bl);
            chk("overflow_o", int'(overflow_o), m_ovf);
        end
    end

    int  d_rises = 0;
    logic prev_p = 1'b0;
    always begin
        @(posedge CLK);
        #1;
        if (pulse_o === 1'b1 && prev_p !== 1'b1) d_rises++;
        prev_p = pulse_o;
    end

    task automatic cyc(input logic ev);
        event_i = ev;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        RST = 1'b0;
    endtask

    int r0;
    int s0;

    initial begin
        RST     = 1'b1;
        event_i = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST    = 1'b0;
        cmp_en = 1'b1;
        chk("rst_pulse", int'(pulse_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_pend", int'(pending_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);
        idle(3);

        // Single event: 4 high, 4 low, busy drops after 8 edges.
        r0 = d_rises;
        cyc(1'b1);
        chk("t1_first_high", int'(pulse_o), 1);
        chk("t1_pend", int'(pending_o), 0);
        idle(3);
        chk("t1_last_high", int'(pulse_o), 1);
        idle(1);
        chk("t1_first_low", int'(pulse_o), 0);
        idle(3);
        chk("t1_busy_low_last", int'(busy_o), 1);
        idle(1);
        chk("t1_busy_drop", int'(busy_o), 0);
        chk("t1_rises", d_rises - r0, 1);

        // Event on the final LOW cycle restarts with no idle bubble.
        idle(2);
        cyc(1'b1);
        idle(7);
        chk("t4_low_end", int'(pulse_o), 0);
        cyc(1'b1);
        chk("t4_restart", int'(pulse_o), 1);
        chk("t4_pend", int'(pending_o), 0);
        idle(12);

        // Three back-to-back strobes.
        r0 = d_rises;
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
`ifndef SYNC_PULSE_SRC_COALESCE_EN
        chk("t2_pend2", int'(pending_o), 2);
`else
        chk("t2_pend1", int'(pending_o), 1);
`endif
        idle(30);
        chk("t2_rises", d_rises - r0, COAL ? 2 : 3);
        chk("t2_pend0", int'(pending_o), 0);
        chk("t2_ovf", int'(overflow_o), 0);

`ifndef SYNC_PULSE_SRC_COALESCE_EN
        // Held event: backlog saturates, overflow sticks.
        r0 = d_rises;
        s0 = m_starts;
        for (int i = 0; i < 18; i++) cyc(1'b1);
        chk("t3_sat", int'(pending_o), 15);
        chk("t3_no_ovf_yet", int'(overflow_o), 0);
        cyc(1'b1);
        chk("t3_ovf", int'(overflow_o), 1);
        chk("t3_sat_hold", int'(pending_o), 15);
        cyc(1'b1);
        idle(170);
        chk("t3_ovf_sticky", int'(overflow_o), 1);
        chk("t3_rises", d_rises - r0, m_starts - s0);
        chk("t3_drain", int'(pending_o), 0);
`else
        // Several events during one HIGH phase collapse into one more pulse.
        r0 = d_rises;
        cyc(1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1);
        chk("t6_pend1", int'(pending_o), 1);
        chk("t6_ovf", int'(overflow_o), 0);
        idle(30);
        chk("t6_rises", d_rises - r0, 2);
`endif

        // Reset in the second HIGH cycle of a pulse with a backlog.
        do_reset();
        chk("t5_ovf_clr", int'(overflow_o), 0);
        for (int i = 0; i < 5; i++) cyc(1'b1);
        idle(4);
        cyc(1'b0);
        chk("t5_high2", int'(pulse_o), 1);
`ifndef SYNC_PULSE_SRC_COALESCE_EN
        chk("t5_pend3", int'(pending_o), 3);
`endif
        RST = 1'b1;
        cyc(1'b0);
        RST = 1'b0;
        chk("t5_pulse", int'(pulse_o), 0);
        chk("t5_pend", int'(pending_o), 0);
        chk("t5_busy", int'(busy_o), 0);
        chk("t5_ovf", int'(overflow_o), 0);
        r0 = d_rises;
        idle(30);
        chk("t5_quiet", d_rises - r0, 0);

        // Random traffic with varying density and rare resets.
        r0 = d_rises;
        s0 = m_starts;
        for (int blk = 0; blk < 6; blk++) begin
            int pct;
            pct = $urandom_range(5, 90);
            for (int i = 0; i < 500; i++) begin
                RST = ($urandom_range(0, 399) == 0);
                cyc($urandom_range(0, 99) < pct);
            end
        end
        RST = 1'b0;
        idle(300);
        chk("rand_rises", d_rises - r0, m_starts - s0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
